// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: MULTU/MULT by shift-add, DIVU/DIV by restoring
// division, sharing one WIDTH+1-bit add/subtract path; results land in HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DZ
);

    // state | meaning
    // IDLE  | waiting for START
    // CALC  | WIDTH iterations, one result bit per cycle
    // FIX   | sign correction, HI/LO/DZ loaded on exit
    // FIN   | DONE pulse; a new START is accepted here
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic               sa, sb, dz_q;
    logic [WIDTH-1:0]   opb, a_orig;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_x, add_y, sum;
    logic               add_sub;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quo, rem, hi_n, lo_n;

    // The most-negative value has no positive twin; it passes through as unsigned.
    assign abs_a = (OP[0] && A[WIDTH-1]) ? -A : A;
    assign abs_b = (OP[0] && B[WIDTH-1]) ? -B : B;

    always_comb begin
        add_sub = op_q[1];
        if (op_q[1]) begin
            add_x = acc[2*WIDTH-1:WIDTH-1];
            add_y = {1'b0, opb};
        end else begin
            add_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
            add_y = acc[0] ? {1'b0, opb} : '0;
        end
        sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};

        // Divide: sum[WIDTH] set means the trial subtraction went negative, so restore.
        if (op_q[1])
            acc_step = sum[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        prod = (op_q[0] && (sa ^ sb)) ? -acc : acc;
        quo  = (op_q[0] && (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = (op_q[0] && sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!op_q[1]) begin
            hi_n = prod[2*WIDTH-1:WIDTH];
            lo_n = prod[WIDTH-1:0];
        end else if (dz_q) begin
            hi_n = a_orig;
            lo_n = '1;
        end else begin
            hi_n = rem;
            lo_n = quo;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            DZ     <= 1'b0;
            op_q   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz_q   <= 1'b0;
            opb    <= '0;
            a_orig <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        op_q   <= OP;
                        sa     <= OP[0] & A[WIDTH-1];
                        sb     <= OP[0] & B[WIDTH-1];
                        dz_q   <= OP[1] && (B == '0);
                        a_orig <= A;
                        opb    <= OP[1] ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, (OP[1] ? abs_a : abs_b)};
                        cnt    <= '0;
                        BUSY   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    HI    <= hi_n;
                    LO    <= lo_n;
                    DZ    <= dz_q;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= FIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32): hand-computed products, quotients,
// latency, back-to-back, ignored START, divide-by-zero and mid-operation reset.
module tb_mult_div_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY, DONE, DZ;
    logic [31:0] HI, LO;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int busy_gaps;
    int done_cnt;

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO), .DZ(DZ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the next posedge is the start edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1; OP = op; A = a; B = b;
        @(posedge CLK); #1;
        START = 1'b0; OP = 2'b00; A = 32'h1234_5678; B = 32'h0000_0009;
    endtask

    // Returns at the negedge where DONE is seen; cycle 1 is the one after the start edge.
    task automatic wait_done(input int p1, input int p2);
        lat = 999;
        busy_gaps = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLK);
            if (DONE) begin
                lat = i;
                break;
            end
            if (BUSY !== 1'b1) busy_gaps++;
            if (i == p1 || i == p2) begin
                START = 1'b1; OP = 2'b00; A = 32'd5; B = 32'd5;
                @(posedge CLK); #1;
                START = 1'b0;
            end
        end
        check("latency", 64'(lat), 64'd34);
        check("busy_during_op", 64'(busy_gaps), 64'd0);
        check("busy_at_done", {63'd0, BUSY}, 64'd0);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        wait_done(-1, -1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        check("rst_done", {63'd0, DONE}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        check("rst_dz", {63'd0, DZ}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", {32'd0, HI}, 64'hFFFF_FFFE);
        check("multu_max_lo", {32'd0, LO}, 64'h0000_0001);
        check("multu_max_dz", {63'd0, DZ}, 64'd0);
        @(negedge CLK);
        check("done_one_cycle", {63'd0, DONE}, 64'd0);
        check("hi_hold", {32'd0, HI}, 64'hFFFF_FFFE);

        @(negedge CLK);
        run(2'b01, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("mult_neg_lo", {32'd0, LO}, 64'hFFFF_FFEB);
        run(2'b11, 32'hFFFF_FFF9, 32'd2);
        check("b2b_div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
        check("b2b_div_hi", {32'd0, HI}, 64'hFFFF_FFFF);

        @(negedge CLK);
        run(2'b10, 32'd100, 32'd0);
        check("divu_dz_hi", {32'd0, HI}, 64'h0000_0064);
        check("divu_dz_lo", {32'd0, LO}, 64'hFFFF_FFFF);
        check("divu_dz_dz", {63'd0, DZ}, 64'd1);
        @(negedge CLK);
        run(2'b00, 32'd3, 32'd5);
        check("multu_small_hi", {32'd0, HI}, 64'd0);
        check("multu_small_lo", {32'd0, LO}, 64'd15);
        check("multu_small_dz", {63'd0, DZ}, 64'd0);

        run(2'b11, 32'hFFFF_FFFB, 32'd0);
        check("div_dz_hi", {32'd0, HI}, 64'hFFFF_FFFB);
        check("div_dz_lo", {32'd0, LO}, 64'hFFFF_FFFF);
        check("div_dz_dz", {63'd0, DZ}, 64'd1);

        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_minneg_lo", {32'd0, LO}, 64'h8000_0000);
        check("div_minneg_hi", {32'd0, HI}, 64'd0);
        check("div_minneg_dz", {63'd0, DZ}, 64'd0);
        run(2'b10, 32'h8000_0000, 32'd3);
        check("divu_big_lo", {32'd0, LO}, 64'h2AAA_AAAA);
        check("divu_big_hi", {32'd0, HI}, 64'd2);

        @(negedge CLK);
        start_op(2'b10, 32'd1000, 32'd7);
        wait_done(5, 20);
        check("divu_ign_lo", {32'd0, LO}, 64'd142);
        check("divu_ign_hi", {32'd0, HI}, 64'd6);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        check("no_extra_done", 64'(done_cnt), 64'd0);

        start_op(2'b00, 32'd100, 32'd200);
        repeat (9) @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1; START = 1'b1; OP = 2'b00; A = 32'd9; B = 32'd9;
        @(posedge CLK); #1;
        RST = 1'b0; START = 1'b0;
        @(negedge CLK);
        check("abort_busy", {63'd0, BUSY}, 64'd0);
        check("abort_done", {63'd0, DONE}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run(2'b00, 32'd6, 32'd7);
        check("after_abort_lo", {32'd0, LO}, 64'd42);
        check("after_abort_hi", {32'd0, HI}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
